pool2d_cfg: RTL and testbench

- Runtime-configurable 2-D pooling stage on the frame bus: max or average over non-overlapping 2^k x 2^k windows (stride = window), all CHANNELS in parallel.
- Sits downstream of conv3d in the inference chain and uses the same frame-bus protocol (frame_start / valid / data, raster order, one pixel per beat, no back-pressure).
- Next generation of the fixed pooling path: adds runtime window size, runtime mode, edge cropping and mid-frame restart handling.

---
 rtl/nnfpga_pool_pkg.sv | 25 ++
 rtl/pool_combine.sv | 37 +++
 rtl/pool2d_cfg.sv | 194 +++++++++++++++++++
 tb/tb_pool2d_cfg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnfpga_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nnfpga_pool_pkg
// Brief   : Shared types and helpers for the pooling stages of the frame bus.
// Revision: 1.0 - initial release
// ============================================================================
package nnfpga_pool_pkg;

  typedef enum logic [0:0] {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pool_state_t;

  // Accumulator must hold the sum of (2^k)^2 samples at the largest k.
  function automatic int acc_w(input int data_width, input int win_log2_max);
    return data_width + 2 * win_log2_max;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_combine.sv
`default_nettype none
// ============================================================================
// Module  : pool_combine
// Brief   : Per-channel accumulator update: load, signed max or signed sum.
// Revision: 1.0 - initial release
// ============================================================================
module pool_combine
  import nnfpga_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 12
) (
  input  logic                  i_first,
  input  pool_mode_t            i_mode,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic [ACC_W-1:0]      i_acc,
  output logic [ACC_W-1:0]      o_result
);

  logic signed [ACC_W-1:0] w_ext;

  assign w_ext = ACC_W'($signed(i_sample));

  // First pixel of a window loads; later pixels fold into the running value.
  always_comb begin
    o_result = w_ext;
    if (!i_first) begin
      if (i_mode == POOL_MAX) begin
        o_result = ($signed(i_acc) > w_ext) ? i_acc : w_ext;
      end else begin
        o_result = i_acc + w_ext;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool2d_cfg.sv
`default_nettype none
// ============================================================================
// Module  : pool2d_cfg
// Brief   : Runtime-configurable 2^k x 2^k max/average pooling on the frame
//           bus, all channels in parallel, with crop and mid-frame restart.
// Revision: 1.0 - initial release
// ============================================================================
module pool2d_cfg
  import nnfpga_pool_pkg::*;
#(
  parameter int FRAME_H_MAX  = 256,
  parameter int FRAME_W_MAX  = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 4,
  parameter int WIN_LOG2_MAX = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [$clog2(FRAME_H_MAX+1)-1:0]     frame_h,
  input  logic [$clog2(FRAME_W_MAX+1)-1:0]     frame_w,
  input  logic [$clog2(WIN_LOG2_MAX+1)-1:0]    win_log2,
  input  logic                                 mode,
  input  logic                                 fin_start,
  input  logic                                 din_vld,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       din,
  output logic                                 fout_start,
  output logic                                 dout_vld,
  output logic [CHANNELS*DATA_WIDTH-1:0]       dout,
  output logic                                 frm_abort
);

  localparam int c_FH_W  = $clog2(FRAME_H_MAX + 1);
  localparam int c_FW_W  = $clog2(FRAME_W_MAX + 1);
  localparam int c_K_W   = $clog2(WIN_LOG2_MAX + 1);
  localparam int c_OX_W  = (FRAME_W_MAX > 1) ? $clog2(FRAME_W_MAX) : 1;
  localparam int c_ACC_W = acc_w(DATA_WIDTH, WIN_LOG2_MAX);
  localparam int c_PIX_W = CHANNELS * DATA_WIDTH;

  pool_state_t               r_state;
  logic [c_FH_W-1:0]         r_fh, r_y;
  logic [c_FW_W-1:0]         r_fw, r_x;
  logic [c_K_W-1:0]          r_k;
  pool_mode_t                r_mode;
  logic                      r_pend;
  logic                      r_abort_p;
  logic [CHANNELS*c_ACC_W-1:0] r_acc [FRAME_W_MAX];

  logic                      r_s1_vld, r_s1_start;
  pool_mode_t                r_s1_mode;
  logic [c_K_W-1:0]          r_s1_k;
  logic [CHANNELS*c_ACC_W-1:0] r_s1_acc;
  logic                      r_s2_vld, r_s2_start;
  logic [c_PIX_W-1:0]        r_s2_res;

  logic                      r_dout_vld, r_fout_start, r_frm_abort;
  logic [c_PIX_W-1:0]        r_dout;

  logic                      w_start, w_acc, w_in, w_first, w_last, w_emit, w_pend;
  logic                      w_x_end, w_y_end;
  logic [c_FH_W-1:0]         w_fh, w_y, w_mask_y;
  logic [c_FW_W-1:0]         w_fw, w_x, w_mask_x;
  logic [c_K_W-1:0]          w_k;
  pool_mode_t                w_mode;
  logic [c_OX_W-1:0]         w_ox;
  logic [CHANNELS*c_ACC_W-1:0] w_acc_rd, w_comb;
  logic [c_PIX_W-1:0]        w_res;

  // A start beat is always accepted and supplies both config and pixel (0,0).
  assign w_start  = din_vld & fin_start;
  assign w_acc    = din_vld & (fin_start | (r_state == RUN));
  assign w_fh     = w_start ? frame_h : r_fh;
  assign w_fw     = w_start ? frame_w : r_fw;
  assign w_k      = w_start ? win_log2 : r_k;
  assign w_mode   = w_start ? pool_mode_t'(mode) : r_mode;
  assign w_x      = w_start ? '0 : r_x;
  assign w_y      = w_start ? '0 : r_y;

  // Window offsets are the low k bits of the position; crop keeps whole windows.
  assign w_mask_x = ~({c_FW_W{1'b1}} << w_k);
  assign w_mask_y = ~({c_FH_W{1'b1}} << w_k);
  assign w_in     = (w_x < (w_fw & ~w_mask_x)) && (w_y < (w_fh & ~w_mask_y));
  assign w_first  = ((w_x & w_mask_x) == '0) && ((w_y & w_mask_y) == '0);
  assign w_last   = ((w_x & w_mask_x) == w_mask_x) && ((w_y & w_mask_y) == w_mask_y);
  assign w_ox     = c_OX_W'(w_x >> w_k);
  assign w_acc_rd = r_acc[w_ox];
  assign w_emit   = w_acc & w_in & w_last;
  assign w_pend   = w_start | r_pend;
  assign w_x_end  = (w_x == w_fw - 1'b1);
  assign w_y_end  = (w_y == w_fh - 1'b1);

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [c_ACC_W:0] w_ext, w_bias;
      logic [c_K_W:0]          w_sh;

      pool_combine #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (c_ACC_W)
      ) u_combine (
        .i_first  (w_first),
        .i_mode   (w_mode),
        .i_sample (din[c*DATA_WIDTH +: DATA_WIDTH]),
        .i_acc    (w_acc_rd[c*c_ACC_W +: c_ACC_W]),
        .o_result (w_comb[c*c_ACC_W +: c_ACC_W])
      );

      // Average divides by 4^k with round-half-up; k = 0 leaves the sum as is.
      assign w_ext  = (c_ACC_W+1)'($signed(r_s1_acc[c*c_ACC_W +: c_ACC_W]));
      assign w_sh   = {r_s1_k, 1'b0};
      assign w_bias = (r_s1_k == '0) ? '0 : ((c_ACC_W+1)'(1) << (w_sh - 1'b1));
      assign w_res[c*DATA_WIDTH +: DATA_WIDTH] = (r_s1_mode == POOL_AVG) ?
          DATA_WIDTH'((w_ext + w_bias) >>> w_sh) :
          r_s1_acc[c*c_ACC_W +: DATA_WIDTH];
    end
  endgenerate

  // Accumulator storage, one entry per output column; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_acc && w_in) begin
      r_acc[w_ox] <= w_comb;
    end
  end

  // Frame FSM, raster counters and the two-stage output pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_fh         <= '0;
      r_fw         <= '0;
      r_k          <= '0;
      r_mode       <= POOL_MAX;
      r_x          <= '0;
      r_y          <= '0;
      r_pend       <= 1'b0;
      r_abort_p    <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_start   <= 1'b0;
      r_s1_mode    <= POOL_MAX;
      r_s1_k       <= '0;
      r_s1_acc     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_start   <= 1'b0;
      r_s2_res     <= '0;
      r_dout_vld   <= 1'b0;
      r_fout_start <= 1'b0;
      r_frm_abort  <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_abort_p   <= w_start & (r_state == RUN);
      r_frm_abort <= r_abort_p;
      if (w_start) begin
        r_fh   <= frame_h;
        r_fw   <= frame_w;
        r_k    <= win_log2;
        r_mode <= pool_mode_t'(mode);
      end
      if (w_acc) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y + 1'b1;
        end else begin
          r_x <= w_x + 1'b1;
          r_y <= w_y;
        end
        r_state <= (w_x_end && w_y_end) ? IDLE : RUN;
        r_pend  <= w_pend & ~w_emit;
      end
      r_s1_vld   <= w_emit;
      r_s1_start <= w_emit & w_pend;
      if (w_emit) begin
        r_s1_acc  <= w_comb;
        r_s1_mode <= w_mode;
        r_s1_k    <= w_k;
      end
      r_s2_vld   <= r_s1_vld;
      r_s2_start <= r_s1_start;
      if (r_s1_vld) begin
        r_s2_res <= w_res;
      end
      r_dout_vld   <= r_s2_vld;
      r_fout_start <= r_s2_start;
      if (r_s2_vld) begin
        r_dout <= r_s2_res;
      end
    end
  end

  assign dout_vld   = r_dout_vld;
  assign fout_start = r_fout_start;
  assign frm_abort  = r_frm_abort;
  assign dout       = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_pool2d_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_pool2d_cfg
// Brief   : Randomized self-checking bench for pool2d_cfg with a
//           window-level reference model and output scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pool2d_cfg;

  localparam int FH = 256;
  localparam int FW = 256;
  localparam int DW = 8;
  localparam int CH = 4;
  localparam int KM = 2;
  localparam int PW = CH * DW;

  logic          clk, reset_n;
  logic [8:0]    frame_h, frame_w;
  logic [1:0]    win_log2;
  logic          mode, fin_start, din_vld;
  logic [PW-1:0] din;
  logic          fout_start, dout_vld, frm_abort;
  logic [PW-1:0] dout;

  typedef struct {
    logic [PW-1:0] data;
    logic          start;
    longint        t;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           got_q[$];
  longint        abort_t[$];
  logic [PW-1:0] pix [1024];
  longint        btime [1024];
  int            n_checks = 0;
  int            n_errors = 0;

  pool2d_cfg #(
    .FRAME_H_MAX (FH), .FRAME_W_MAX (FW), .DATA_WIDTH (DW),
    .CHANNELS (CH), .WIN_LOG2_MAX (KM)
  ) dut (
    .clk (clk), .reset_n (reset_n), .frame_h (frame_h), .frame_w (frame_w),
    .win_log2 (win_log2), .mode (mode), .fin_start (fin_start),
    .din_vld (din_vld), .din (din), .fout_start (fout_start),
    .dout_vld (dout_vld), .dout (dout), .frm_abort (frm_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && din_vld && fin_start)
      assert (frame_h <= FH && frame_w <= FW && win_log2 <= KM)
        else $error("illegal frame config on fin_start");
  end

  always @(negedge clk) begin
    if (dout_vld) got_q.push_back('{dout, fout_start, $time});
    if (frm_abort) abort_t.push_back($time);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix[i] = $urandom;
  endtask

  // Drives nb raster beats of a frame; only the first carries fin_start/config.
  task automatic drive_frame(input int h, input int w, input int k, input int md,
                             input int maxgap, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      din_vld   = 1'b1;
      fin_start = (i == 0);
      din       = pix[i];
      if (i == 0) begin
        frame_h = 9'(h); frame_w = 9'(w); win_log2 = 2'(k); mode = md[0];
      end else begin
        frame_h  = 9'($urandom_range(FH, 1));
        frame_w  = 9'($urandom_range(FW, 1));
        win_log2 = 2'($urandom_range(KM, 0));
        mode     = 1'($urandom);
      end
      @(posedge clk);
      btime[i] = $time;
      for (int g = $urandom_range(maxgap, 0); g > 0; g--) begin
        @(negedge clk);
        din_vld   = 1'b0;
        fin_start = 1'($urandom);
        din       = $urandom;
      end
    end
    @(negedge clk);
    din_vld   = 1'b0;
    fin_start = 1'b0;
  endtask

  // Reference: pool each complete window reached within nb beats.
  task automatic build_expect(input int h, input int w, input int k, input int md,
                              input int nb);
    int  s, n, ci, idx, a, v, r;
    bit  first;
    ev_t e;
    s = 1 << k;
    n = s * s;
    first = 1'b1;
    for (int oy = 0; oy < (h >> k); oy++) begin
      for (int ox = 0; ox < (w >> k); ox++) begin
        ci = (oy * s + s - 1) * w + ox * s + s - 1;
        if (ci < nb) begin
          e.data = '0;
          for (int c = 0; c < CH; c++) begin
            a = 0;
            for (int dy = 0; dy < s; dy++) begin
              for (int dx = 0; dx < s; dx++) begin
                idx = (oy * s + dy) * w + ox * s + dx;
                v = int'($signed(pix[idx][c*DW +: DW]));
                if (dy == 0 && dx == 0) a = v;
                else if (md == 0) a = (v > a) ? v : a;
                else a = a + v;
              end
            end
            if (md == 1) begin
              a = a + n / 2;
              r = (a >= 0) ? a / n : -((-a + n - 1) / n);
            end else begin
              r = a;
            end
            e.data[c*DW +: DW] = r[DW-1:0];
          end
          e.start = first;
          e.t     = btime[ci] + 25;
          first   = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_ch0(input string tag, input int vals[4]);
    logic [DW-1:0] got, want;
    for (int i = 0; i < 4; i++) begin
      got  = (got_q.size() > i) ? got_q[i].data[DW-1:0] : 'x;
      want = vals[i][DW-1:0];
      check_val(tag, 64'(got), 64'(want));
    end
  endtask

  task automatic compare_all(input int n_abort);
    int m;
    check_val("out_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_val("out_data", 64'(got_q[i].data), 64'(exp_q[i].data));
      check_val("out_start", 64'(got_q[i].start), 64'(exp_q[i].start));
      check_val("out_time", got_q[i].t, exp_q[i].t);
    end
    check_val("abort_count", abort_t.size(), n_abort);
    got_q.delete(); exp_q.delete(); abort_t.delete();
  endtask

  initial begin
    int h, w, k, md, nb, n_ab;
    reset_n = 1'b0; frame_h = '0; frame_w = '0; win_log2 = '0; mode = 1'b0;
    fin_start = 1'b0; din_vld = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_dout_vld", dout_vld, 0);
    check_val("rst_fout_start", fout_start, 0);
    check_val("rst_frm_abort", frm_abort, 0);
    check_val("rst_dout", dout, 0);
    reset_n = 1'b1;

    // 4x4 ramp, k=1, max then average.
    fill_random(16);
    for (int i = 0; i < 16; i++) pix[i][DW-1:0] = 8'(i);
    drive_frame(4, 4, 1, 0, 0, 16); build_expect(4, 4, 1, 0, 16);
    drain(); check_ch0("ramp_max", '{5, 7, 13, 15}); compare_all(0);
    drive_frame(4, 4, 1, 1, 0, 16); build_expect(4, 4, 1, 1, 16);
    drain(); check_ch0("ramp_avg", '{3, 5, 11, 13}); compare_all(0);

    // Negative rounding and most-negative max.
    for (int i = 0; i < 16; i++) pix[i] = (i % 2 == 0) ? {CH{8'hFF}} : {CH{8'hFE}};
    drive_frame(4, 4, 1, 1, 0, 16); build_expect(4, 4, 1, 1, 16);
    drain(); check_ch0("neg_avg", '{-1, -1, -1, -1}); compare_all(0);
    for (int i = 0; i < 16; i++) pix[i] = {CH{8'h80}};
    drive_frame(4, 4, 1, 0, 0, 16); build_expect(4, 4, 1, 0, 16);
    drain(); check_ch0("min_max", '{-128, -128, -128, -128}); compare_all(0);

    // 5x5 crop with idle gaps, then stray beats that IDLE must ignore.
    fill_random(25);
    drive_frame(5, 5, 1, 0, 3, 25); build_expect(5, 5, 1, 0, 25);
    repeat (4) begin
      @(negedge clk); din_vld = 1'b1; fin_start = 1'b0; din = $urandom;
    end
    @(negedge clk); din_vld = 1'b0;
    drain(); check_val("crop_count", got_q.size(), 4); compare_all(0);

    // Restart after 6 beats, then a full frame.
    fill_random(16);
    drive_frame(4, 4, 1, 1, 0, 6); build_expect(4, 4, 1, 1, 6);
    fill_random(16);
    drive_frame(4, 4, 1, 0, 1, 16); build_expect(4, 4, 1, 0, 16);
    drain();
    check_val("abort_time", (abort_t.size() > 0) ? abort_t[0] : -1, btime[0] + 15);
    compare_all(1);

    // k = 0 passthrough, 3 wide x 2 high, both modes.
    fill_random(6);
    drive_frame(2, 3, 0, 0, 1, 6); build_expect(2, 3, 0, 0, 6); drain(); compare_all(0);
    fill_random(6);
    drive_frame(2, 3, 0, 1, 1, 6); build_expect(2, 3, 0, 1, 6); drain(); compare_all(0);

    // Asynchronous reset while results are on the output and in flight.
    for (int i = 0; i < 16; i++) pix[i] = $urandom | {CH{8'h01}};
    drive_frame(4, 4, 0, 0, 0, 4);
    #1;
    check_val("pre_rst_vld", dout_vld, 1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_vld", dout_vld, 0);
    check_val("mid_rst_dout", dout, 0);
    check_val("mid_rst_start", fout_start, 0);
    got_q.delete(); exp_q.delete(); abort_t.delete();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_quiet", got_q.size(), 0);
    reset_n = 1'b1;
    fill_random(16);
    drive_frame(4, 4, 1, 1, 0, 16); build_expect(4, 4, 1, 1, 16); drain(); compare_all(0);

    // Random frames, some cut short by the next frame's start.
    n_ab = 0;
    for (int f = 0; f < 12; f++) begin
      h  = $urandom_range(9, 1);
      w  = $urandom_range(9, 1);
      k  = $urandom_range(KM, 0);
      md = $urandom_range(1, 0);
      nb = (f < 11 && $urandom_range(3, 0) == 0) ? $urandom_range(h * w, 1) : h * w;
      if (nb < h * w) n_ab++;
      fill_random(h * w);
      drive_frame(h, w, k, md, 2, nb);
      build_expect(h, w, k, md, nb);
    end
    drain(); compare_all(n_ab);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
